// File: rtl/trig_pkg.sv
// Shared types for the trigger/capture path: capture state encoding used by the
// controller and by the UI status readback.
package trig_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4
  } cap_state_t;

endpackage

// File: rtl/trig_combine.sv
// Combines the per-channel trigger terms with the protocol trigger and
// registers the result once so the controller sees a clean, glitch-free level.
module trig_combine #(
  parameter int CHANNELS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] ch_trig,
  input  logic                prot_trig,
  output logic                trig_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trig_q <= 1'b0;
    else        trig_q <= (&ch_trig) & prot_trig;
  end

endmodule

// File: rtl/trig_capture_ctrl.sv
// Capture sequencer for the sample RAM: pre-trigger fill, arm, wait for the
// combined trigger, count post-trigger samples, then hold until acknowledged.
module trig_capture_ctrl
  import trig_pkg::*;
#(
  parameter int CHANNELS = 5,
  parameter int ENTRIES  = 384,
  parameter int ADDR_W   = 9
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic                clr_done,
  input  logic                en_sample,
  input  logic [CHANNELS-1:0] CHxTrig,
  input  logic                protTrig,
  input  logic [ADDR_W-1:0]   trig_pos,
  output logic                set_armed,
  output logic                we,
  output logic [ADDR_W-1:0]   waddr,
  output logic                triggered,
  output logic                capture_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ENTRIES - 1);
  localparam logic [ADDR_W:0]   DEPTH     = (ADDR_W+1)'(ENTRIES);

  cap_state_t        state, state_d;
  logic [ADDR_W-1:0] waddr_d;
  logic [ADDR_W:0]   smpl_cnt, smpl_d, smpl_inc;
  logic [ADDR_W:0]   post_cnt, post_d, post_inc;
  logic [ADDR_W-1:0] tpos, tpos_d;
  logic [ADDR_W:0]   fill_tgt;
  logic [ADDR_W:0]   tpos_ext;
  logic              trig_q;
  logic              we_c;

  function automatic logic [ADDR_W-1:0] sat_tpos(input logic [ADDR_W-1:0] tp);
    if (tp > LAST_ADDR) return LAST_ADDR;
    return tp;
  endfunction

  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
    if (a == LAST_ADDR) return '0;
    return a + 1'b1;
  endfunction

  trig_combine #(
    .CHANNELS (CHANNELS)
  ) u_combine (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_trig   (CHxTrig),
    .prot_trig (protTrig),
    .trig_q    (trig_q)
  );

  assign tpos_ext = {1'b0, tpos};
  assign fill_tgt = DEPTH - tpos_ext;
  assign smpl_inc = smpl_cnt + 1'b1;
  assign post_inc = post_cnt + 1'b1;
  assign we       = we_c;

  always_comb begin
    state_d = state;
    we_c    = 1'b0;
    waddr_d = waddr;
    smpl_d  = smpl_cnt;
    post_d  = post_cnt;
    tpos_d  = tpos;
    case (state)
      IDLE: begin
        waddr_d = '0;
        if (run) begin
          state_d = PRE;
          smpl_d  = '0;
          post_d  = '0;
          tpos_d  = sat_tpos(trig_pos);
        end
      end
      PRE: begin
        if (en_sample) begin
          we_c    = 1'b1;
          waddr_d = wrap_inc(waddr);
          smpl_d  = smpl_inc;
          if (smpl_inc == fill_tgt) state_d = ARMED;
        end
      end
      ARMED: begin
        // A sample arriving with the trigger is still written before POST.
        if (en_sample) begin
          we_c    = 1'b1;
          waddr_d = wrap_inc(waddr);
        end
        if (trig_q) begin
          state_d = POST;
          post_d  = '0;
        end
      end
      POST: begin
        // Only reachable with post_cnt==tpos on entry when tpos is zero.
        if (post_cnt == tpos_ext) begin
          state_d = DONE;
        end else if (en_sample) begin
          we_c    = 1'b1;
          waddr_d = wrap_inc(waddr);
          post_d  = post_inc;
          if (post_inc == tpos_ext) state_d = DONE;
        end
      end
      DONE: begin
        if (clr_done) begin
          state_d = IDLE;
          waddr_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      waddr        <= '0;
      smpl_cnt     <= '0;
      post_cnt     <= '0;
      tpos         <= '0;
      set_armed    <= 1'b0;
      triggered    <= 1'b0;
      capture_done <= 1'b0;
    end else begin
      state        <= state_d;
      waddr        <= waddr_d;
      smpl_cnt     <= smpl_d;
      post_cnt     <= post_d;
      tpos         <= tpos_d;
      set_armed    <= (state_d == ARMED) || (state_d == POST);
      triggered    <= (state_d == POST) || (state_d == DONE);
      capture_done <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_trig_capture_ctrl.sv
// Bench for trig_capture_ctrl: an 8-entry and a 384-entry instance share all
// inputs and are each compared against a flag/counter capture model.
module tb_trig_capture_ctrl;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       clr_done;
  logic       en_sample;
  logic [4:0] CHxTrig;
  logic       protTrig;
  logic [8:0] trig_pos;

  logic [1:0] set_armed_v;
  logic [1:0] we_v;
  logic [1:0] triggered_v;
  logic [1:0] done_v;
  logic [8:0] waddr_v [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  trig_capture_ctrl #(.CHANNELS(5), .ENTRIES(8), .ADDR_W(9)) u8 (
    .clk(clk), .rst_n(rst_n), .run(run), .clr_done(clr_done), .en_sample(en_sample),
    .CHxTrig(CHxTrig), .protTrig(protTrig), .trig_pos(trig_pos),
    .set_armed(set_armed_v[0]), .we(we_v[0]), .waddr(waddr_v[0]),
    .triggered(triggered_v[0]), .capture_done(done_v[0])
  );

  trig_capture_ctrl #(.CHANNELS(5), .ENTRIES(384), .ADDR_W(9)) u384 (
    .clk(clk), .rst_n(rst_n), .run(run), .clr_done(clr_done), .en_sample(en_sample),
    .CHxTrig(CHxTrig), .protTrig(protTrig), .trig_pos(trig_pos),
    .set_armed(set_armed_v[1]), .we(we_v[1]), .waddr(waddr_v[1]),
    .triggered(triggered_v[1]), .capture_done(done_v[1])
  );

  // Capture model: flags say how far the capture has progressed.
  typedef struct {
    int E;
    bit active;
    bit armed;
    bit trig;
    bit done;
    bit tq;
    int fill;
    int post;
    int tp;
    int addr;
  } mdl_t;

  typedef struct {
    bit run;
    bit clr;
    bit en;
    bit we;
    bit sa;
    bit tr;
    bit cd;
    int wa;
  } vec_t;

  mdl_t m [2];
  int   ent [2];
  int   pass_cnt;
  int   tot_cnt;
  int   wcnt [2];
  int   pwcnt [2];
  bit   we_seen [2];

  function automatic mdl_t mdl_init(input int e);
    mdl_t s;
    s.E = e; s.active = 0; s.armed = 0; s.trig = 0; s.done = 0; s.tq = 0;
    s.fill = 0; s.post = 0; s.tp = 0; s.addr = 0;
    return s;
  endfunction

  function automatic bit mdl_we(input mdl_t s, input bit e);
    return e && s.active && !(s.trig && s.post == s.tp);
  endfunction

  function automatic mdl_t mdl_step(input mdl_t s, input bit r, input bit c,
                                    input bit e, input bit h, input int tpin);
    mdl_t n;
    bit   wr;
    n  = s;
    wr = mdl_we(s, e);
    if (wr) n.addr = (s.addr + 1) % s.E;
    if (s.done) begin
      if (c) begin n.done = 0; n.trig = 0; n.addr = 0; end
    end else if (!s.active) begin
      n.addr = 0;
      if (r) begin
        n.active = 1; n.fill = 0;
        n.tp = (tpin > s.E - 1) ? s.E - 1 : tpin;
      end
    end else if (!s.armed) begin
      if (e) begin
        n.fill = s.fill + 1;
        if (n.fill == s.E - s.tp) n.armed = 1;
      end
    end else if (!s.trig) begin
      if (s.tq) begin n.trig = 1; n.post = 0; end
    end else begin
      if (wr) n.post = s.post + 1;
      if (n.post == s.tp) begin n.done = 1; n.active = 0; n.armed = 0; end
    end
    n.tq = h;
    return n;
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    tot_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  task automatic check_outs(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s.u%0d.set_armed", tag, i), int'(set_armed_v[i]), int'(m[i].armed));
      chk($sformatf("%s.u%0d.triggered", tag, i), int'(triggered_v[i]), int'(m[i].trig));
      chk($sformatf("%s.u%0d.capture_done", tag, i), int'(done_v[i]), int'(m[i].done));
      chk($sformatf("%s.u%0d.waddr", tag, i), int'(waddr_v[i]), m[i].addr);
    end
  endtask

  task automatic cyc(input bit r, input bit c, input bit e, input bit h, input int tp);
    bit hv;
    @(negedge clk);
    run = r; clr_done = c; en_sample = e; trig_pos = 9'(tp);
    if (h) begin
      CHxTrig = 5'h1f; protTrig = 1'b1;
    end else begin
      CHxTrig = 5'($urandom);
      protTrig = (&CHxTrig) ? 1'b0 : 1'($urandom);
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d.we", i), int'(we_v[i]), int'(mdl_we(m[i], e)));
      we_seen[i] = we_v[i];
      wcnt[i] += int'(we_v[i]);
      if (we_v[i] && triggered_v[i]) pwcnt[i]++;
    end
    @(posedge clk);
    hv = (&CHxTrig) & protTrig;
    for (int i = 0; i < 2; i++) m[i] = mdl_step(m[i], r, c, e, hv, tp);
    #1;
    check_outs("cyc");
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    run = 0; clr_done = 0; en_sample = 0;
    #1;
    for (int i = 0; i < 2; i++) begin
      m[i] = mdl_init(ent[i]);
      chk($sformatf("rst.u%0d.we", i), int'(we_v[i]), 0);
      wcnt[i] = 0; pwcnt[i] = 0;
    end
    check_outs("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tv [13];
  int   base;
  int   pre_w;
  int   tpr;
  int   rr, cc, ee, hh;

  initial begin
    pass_cnt = 0; tot_cnt = 0;
    ent[0] = 8; ent[1] = 384;
    rst_n = 1'b0; run = 0; clr_done = 0; en_sample = 0;
    CHxTrig = '0; protTrig = 1'b0; trig_pos = '0;
    for (int i = 0; i < 2; i++) begin
      m[i] = mdl_init(ent[i]); wcnt[i] = 0; pwcnt[i] = 0; we_seen[i] = 0;
    end

    // Table for the 8-entry instance: trig_pos=3, en every clk, trigger held high.
    tv[0]  = '{1, 0, 1, 0, 0, 0, 0, 0};
    tv[1]  = '{0, 0, 1, 1, 0, 0, 0, 1};
    tv[2]  = '{0, 0, 1, 1, 0, 0, 0, 2};
    tv[3]  = '{0, 0, 1, 1, 0, 0, 0, 3};
    tv[4]  = '{0, 0, 1, 1, 0, 0, 0, 4};
    tv[5]  = '{0, 0, 1, 1, 1, 0, 0, 5};
    tv[6]  = '{0, 0, 1, 1, 1, 1, 0, 6};
    tv[7]  = '{0, 0, 1, 1, 1, 1, 0, 7};
    tv[8]  = '{0, 0, 1, 1, 1, 1, 0, 0};
    tv[9]  = '{0, 0, 1, 1, 0, 1, 1, 1};
    tv[10] = '{0, 0, 1, 0, 0, 1, 1, 1};
    tv[11] = '{1, 1, 1, 0, 0, 0, 0, 0};
    tv[12] = '{0, 0, 1, 0, 0, 0, 0, 0};

    #12;
    check_outs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven main capture
    for (int k = 0; k < 13; k++) begin
      cyc(tv[k].run, tv[k].clr, tv[k].en, 1'b1, 3);
      chk($sformatf("tbl%0d.we", k), int'(we_seen[0]), int'(tv[k].we));
      chk($sformatf("tbl%0d.set_armed", k), int'(set_armed_v[0]), int'(tv[k].sa));
      chk($sformatf("tbl%0d.triggered", k), int'(triggered_v[0]), int'(tv[k].tr));
      chk($sformatf("tbl%0d.capture_done", k), int'(done_v[0]), int'(tv[k].cd));
      chk($sformatf("tbl%0d.waddr", k), int'(waddr_v[0]), tv[k].wa);
    end
    chk("tbl.total_writes", wcnt[0], 9);
    chk("tbl.post_writes", pwcnt[0], 3);

    // Trigger pulse during PRE is ignored
    async_reset();
    cyc(1, 0, 1, 0, 3);
    for (int k = 0; k < 12; k++) cyc(0, 0, 1, (k == 1), 3);
    chk("prepulse.armed", int'(set_armed_v[0]), 1);
    chk("prepulse.not_trig", int'(triggered_v[0]), 0);
    cyc(0, 0, 1, 1, 3);
    for (int k = 0; k < 20 && !done_v[0]; k++) cyc(0, 0, 1, 0, 3);
    chk("prepulse.done", int'(done_v[0]), 1);
    chk("prepulse.post_writes", pwcnt[0], 3);

    // trig_pos=0: no post writes, waddr at oldest sample
    async_reset();
    cyc(1, 0, 1, 1, 0);
    for (int k = 0; k < 30 && !done_v[0]; k++) cyc(0, 0, 1, 1, 0);
    chk("tp0.done", int'(done_v[0]), 1);
    chk("tp0.post_writes", pwcnt[0], 0);
    chk("tp0.total_writes", wcnt[0], 9);
    chk("tp0.waddr_oldest", int'(waddr_v[0]), wcnt[0] % 8);

    // trig_pos saturation on the 384-entry instance
    async_reset();
    pre_w = -1;
    cyc(1, 0, 1, 1, 500);
    for (int k = 0; k < 1000 && !done_v[1]; k++) begin
      cyc(0, 0, 1, 1, 500);
      if (pre_w < 0 && set_armed_v[1]) pre_w = wcnt[1];
    end
    chk("sat.done", int'(done_v[1]), 1);
    chk("sat.pre_writes", pre_w, 1);
    chk("sat.post_writes", pwcnt[1], 383);
    chk("sat.waddr", int'(waddr_v[1]), wcnt[1] % 384);

    // Sparse en_sample, ignored run/clr_done, clr_done+run in DONE
    async_reset();
    cyc(1, 0, 0, 0, 3);
    for (int k = 0; k < 60 && !set_armed_v[0]; k++) cyc(0, 0, (k % 4 == 3), 0, 3);
    chk("sparse.armed", int'(set_armed_v[0]), 1);
    cyc(0, 1, 0, 0, 3);
    chk("sparse.clr_in_armed", int'(set_armed_v[0]), 1);
    cyc(0, 0, 0, 1, 3);
    for (int k = 0; k < 4 && !triggered_v[0]; k++) cyc(0, 0, 0, 0, 3);
    chk("sparse.triggered", int'(triggered_v[0]), 1);
    pwcnt[0] = 0;
    cyc(1, 0, 0, 0, 3);
    for (int k = 0; k < 40 && !done_v[0]; k++) cyc(0, 0, (k % 4 == 3), 0, 3);
    chk("sparse.done", int'(done_v[0]), 1);
    chk("sparse.post_writes", pwcnt[0], 3);
    cyc(1, 1, 1, 0, 3);
    chk("sparse.clr_wins", int'(done_v[0]), 0);
    base = wcnt[0];
    for (int k = 0; k < 8; k++) cyc(0, 0, 1, 0, 3);
    chk("sparse.no_new_capture", wcnt[0] - base, 0);

    // Async reset mid-POST, then a normal capture
    async_reset();
    cyc(1, 0, 0, 1, 3);
    for (int k = 0; k < 60 && !triggered_v[0]; k++) cyc(0, 0, (k % 4 == 3), 1, 3);
    chk("midpost.in_post", int'(triggered_v[0] && !done_v[0]), 1);
    async_reset();
    cyc(1, 0, 1, 1, 3);
    for (int k = 0; k < 30 && !done_v[0]; k++) cyc(0, 0, 1, 1, 3);
    chk("midpost.rerun_writes", wcnt[0], 9);
    chk("midpost.rerun_waddr", int'(waddr_v[0]), 1);

    // Randomized traffic against the model
    async_reset();
    tpr = 3;
    for (int k = 0; k < 3000; k++) begin
      rr = ($urandom_range(0, 29) == 0) ? 1 : 0;
      cc = ($urandom_range(0, 7) == 0) ? 1 : 0;
      ee = ($urandom_range(0, 2) != 0) ? 1 : 0;
      hh = ($urandom_range(0, 9) == 0) ? 1 : 0;
      if (rr != 0)
        tpr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 9));
      cyc(rr != 0, cc != 0, ee != 0, hh != 0, tpr);
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
